// File: rtl/fetch_unit.sv
// Instruction fetch stage. Holds the PC and fetches one word at a time over the
// req/gnt/rvalid handshake. Retires or redirects the instruction on an unstalled
// cycle, halts on illegal or misaligned flow, and counts retired instructions.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic        o_inst_vld,
    input  logic        i_stall,
    input  logic        i_pc_sel,
    input  logic [31:0] i_alu_data,
    input  logic        i_insn_vld,
    output logic        o_halted,
    output logic [1:0]  o_halt_cause,
    output logic [31:0] o_retired
);

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        HOLD       = 2'd2,
        HALT       = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b10;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

    state_t      state_r;
    state_t      state_nx_s;
    logic [31:0] pc_r;
    logic [31:0] pc_nx_s;
    logic [31:0] inst_r;
    logic [31:0] inst_nx_s;
    logic [31:0] retired_r;
    logic [31:0] retired_nx_s;
    logic [1:0]  cause_r;
    logic [1:0]  cause_nx_s;

    // Next-state, PC, instruction and counter computation for the fetch FSM.
    always_comb begin
        state_nx_s   = state_r;
        pc_nx_s      = pc_r;
        inst_nx_s    = inst_r;
        retired_nx_s = retired_r;
        cause_nx_s   = cause_r;
        case (state_r)
            FETCH_REQ: begin
                if (i_imem_gnt) begin
                    state_nx_s = FETCH_WAIT;
                end else begin
                    state_nx_s = FETCH_REQ;
                end
            end
            FETCH_WAIT: begin
                if (i_imem_rvalid) begin
                    inst_nx_s  = i_imem_rdata;
                    state_nx_s = HOLD;
                end else begin
                    state_nx_s = FETCH_WAIT;
                end
            end
            HOLD: begin
                if (i_stall) begin
                    state_nx_s = HOLD;
                end else if (!i_insn_vld) begin
                    state_nx_s = HALT;
                    cause_nx_s = CAUSE_ILLEGAL;
                end else if (i_pc_sel && is_misaligned(i_alu_data[1:0])) begin
                    // PC stays on the faulting instruction so software can locate it
                    state_nx_s = HALT;
                    cause_nx_s = CAUSE_MISALIGN;
                end else begin
                    retired_nx_s = retired_r + 32'd1;
                    pc_nx_s      = i_pc_sel ? i_alu_data : (pc_r + 32'd4);
                    inst_nx_s    = NOP_INST;
                    state_nx_s   = FETCH_REQ;
                end
            end
            HALT: begin
                state_nx_s = HALT;
            end
            default: begin
                state_nx_s = FETCH_REQ;
                inst_nx_s  = NOP_INST;
                cause_nx_s = CAUSE_NONE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r   <= FETCH_REQ;
            pc_r      <= RESET_PC;
            inst_r    <= NOP_INST;
            retired_r <= 32'd0;
            cause_r   <= CAUSE_NONE;
        end else begin
            state_r   <= state_nx_s;
            pc_r      <= pc_nx_s;
            inst_r    <= inst_nx_s;
            retired_r <= retired_nx_s;
            cause_r   <= cause_nx_s;
        end
    end

    // Reset masks the state-decoded strobes so nothing is requested or executed while it is held.
    assign o_imem_req   = (state_r == FETCH_REQ) & ~i_reset;
    assign o_inst_vld   = (state_r == HOLD) & ~i_reset;
    assign o_halted     = (state_r == HALT);
    assign o_halt_cause = cause_r;
    assign o_imem_addr  = pc_r;
    assign o_pc         = pc_r;
    assign o_inst       = inst_r;
    assign o_retired    = retired_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a table of fetch/consume records plus
// hand-written reset-in-flight sequences.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt = 1'b0;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = 32'h0;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        o_inst_vld;
    logic        i_stall = 1'b0;
    logic        i_pc_sel = 1'b0;
    logic [31:0] i_alu_data = 32'h0;
    logic        i_insn_vld = 1'b1;
    logic        o_halted;
    logic [1:0]  o_halt_cause;
    logic [31:0] o_retired;

    int checks = 0;
    int failures = 0;

    fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .NOP_INST(NOP)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .o_imem_req(o_imem_req),
        .o_imem_addr(o_imem_addr),
        .i_imem_gnt(i_imem_gnt),
        .i_imem_rvalid(i_imem_rvalid),
        .i_imem_rdata(i_imem_rdata),
        .o_inst(o_inst),
        .o_pc(o_pc),
        .o_inst_vld(o_inst_vld),
        .i_stall(i_stall),
        .i_pc_sel(i_pc_sel),
        .i_alu_data(i_alu_data),
        .i_insn_vld(i_insn_vld),
        .o_halted(o_halted),
        .o_halt_cause(o_halt_cause),
        .o_retired(o_retired)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit          rst_before;
        logic [31:0] word;
        int          gnt_dly;
        int          rv_lat;
        int          stall;
        logic        pc_sel;
        logic [31:0] alu;
        logic        insn_vld;
        logic [31:0] exp_pc;
        logic [31:0] exp_next;
        logic [31:0] exp_ret;
        logic        exp_halt;
        logic [1:0]  exp_cause;
    } vec_t;

    vec_t vecs [0:10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_imem_gnt = 1'b0;
        i_imem_rvalid = 1'b0;
        i_stall = 1'b0;
        #1;
        chk("rst_req_low", o_imem_req, 32'd0);
        chk("rst_vld_low", o_inst_vld, 32'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        #1;
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_inst", o_inst, NOP);
        chk("rst_halted", o_halted, 32'd0);
        chk("rst_cause", o_halt_cause, 32'd0);
        chk("rst_retired", o_retired, 32'd0);
        chk("rst_first_req", o_imem_req, 32'd1);
    endtask

    // Plays the memory side of one fetch; latency is enforced by the fixed loop lengths.
    task automatic serve(input int gnt_dly, input int rv_lat, input logic [31:0] word);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k <= gnt_dly; k++) begin
            if (o_imem_req !== 1'b1 || o_inst_vld !== 1'b0) bad = 1'b1;
            i_imem_gnt = (k == gnt_dly);
            i_imem_rvalid = (k < gnt_dly);
            i_imem_rdata = 32'hBAD0_BAD0;
            @(negedge i_clk);
        end
        i_imem_gnt = 1'b0;
        for (int k = 1; k <= rv_lat; k++) begin
            if (o_imem_req !== 1'b0 || o_inst_vld !== 1'b0) bad = 1'b1;
            i_imem_rvalid = (k == rv_lat);
            i_imem_rdata = (k == rv_lat) ? word : 32'hDEAD_BEEF;
            @(negedge i_clk);
        end
        i_imem_rvalid = 1'b0;
        chk("handshake_phases", bad, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        logic bad;
        logic [31:0] pre_ret;
        pre_ret = v.exp_halt ? v.exp_ret : (v.exp_ret - 32'd1);
        if (v.rst_before) do_reset();
        chk("req_addr", o_imem_addr, v.exp_pc);
        serve(v.gnt_dly, v.rv_lat, v.word);
        chk("hold_vld", o_inst_vld, 32'd1);
        chk("hold_pc", o_pc, v.exp_pc);
        chk("hold_inst", o_inst, v.word);
        bad = 1'b0;
        for (int s = 0; s < v.stall; s++) begin
            i_stall = 1'b1;
            i_pc_sel = 1'b1;
            i_alu_data = 32'h0000_0202;
            i_insn_vld = 1'b0;
            @(negedge i_clk);
            if (o_inst_vld !== 1'b1 || o_pc !== v.exp_pc || o_inst !== v.word ||
                o_imem_req !== 1'b0 || o_retired !== pre_ret || o_halted !== 1'b0) bad = 1'b1;
        end
        chk("stall_stable", bad, 32'd0);
        i_stall = 1'b0;
        i_pc_sel = v.pc_sel;
        i_alu_data = v.alu;
        i_insn_vld = v.insn_vld;
        @(negedge i_clk);
        i_pc_sel = 1'b0;
        i_insn_vld = 1'b1;
        chk("retired", o_retired, v.exp_ret);
        chk("next_pc", o_pc, v.exp_next);
        chk("halted", o_halted, v.exp_halt);
        chk("cause", o_halt_cause, v.exp_cause);
        chk("inst_after", o_inst, v.exp_halt ? v.word : NOP);
        chk("vld_after", o_inst_vld, 32'd0);
        chk("req_after", o_imem_req, v.exp_halt ? 32'd0 : 32'd1);
        if (v.exp_halt) begin
            bad = 1'b0;
            for (int s = 0; s < 3; s++) begin
                i_imem_gnt = 1'b1;
                @(negedge i_clk);
                if (o_imem_req !== 1'b0 || o_halted !== 1'b1 || o_pc !== v.exp_next ||
                    o_retired !== v.exp_ret || o_halt_cause !== v.exp_cause) bad = 1'b1;
            end
            i_imem_gnt = 1'b0;
            chk("halt_sticky", bad, 32'd0);
        end
    endtask

    initial begin
        vec_t one;
        vecs[0]  = '{1'b1, 32'h0050_0093, 0, 1, 0, 1'b0, 32'h0,         1'b1, 32'h0,         32'h4,         32'd1, 1'b0, 2'b00};
        vecs[1]  = '{1'b0, 32'h0010_0113, 2, 3, 0, 1'b0, 32'h0,         1'b1, 32'h4,         32'h8,         32'd2, 1'b0, 2'b00};
        vecs[2]  = '{1'b0, 32'h0020_8193, 2, 3, 0, 1'b1, 32'h40,        1'b1, 32'h8,         32'h40,        32'd3, 1'b0, 2'b00};
        vecs[3]  = '{1'b0, 32'h0000_006f, 0, 1, 4, 1'b1, 32'h80,        1'b1, 32'h40,        32'h80,        32'd4, 1'b0, 2'b00};
        vecs[4]  = '{1'b0, 32'h0000_0013, 1, 2, 0, 1'b0, 32'h123,       1'b1, 32'h80,        32'h84,        32'd5, 1'b0, 2'b00};
        vecs[5]  = '{1'b0, 32'hffdf_f06f, 0, 1, 1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h84,        32'hFFFF_FFFC, 32'd6, 1'b0, 2'b00};
        vecs[6]  = '{1'b0, 32'h0000_0013, 0, 1, 0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'h0,         32'd7, 1'b0, 2'b00};
        vecs[7]  = '{1'b0, 32'h0100_006f, 0, 2, 0, 1'b1, 32'h10,        1'b1, 32'h0,         32'h10,        32'd8, 1'b0, 2'b00};
        vecs[8]  = '{1'b0, 32'hFFFF_FFFF, 1, 1, 2, 1'b0, 32'h0,         1'b0, 32'h10,        32'h10,        32'd8, 1'b1, 2'b01};
        vecs[9]  = '{1'b1, 32'h0050_0093, 0, 1, 0, 1'b0, 32'h0,         1'b1, 32'h0,         32'h4,         32'd1, 1'b0, 2'b00};
        vecs[10] = '{1'b0, 32'h0000_0067, 0, 1, 0, 1'b1, 32'h22,        1'b1, 32'h4,         32'h4,         32'd1, 1'b1, 2'b10};

        for (int i = 0; i <= 10; i++) begin
            run_vec(vecs[i]);
        end

        one = '{1'b0, 32'h0050_0093, 0, 1, 0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h4, 32'd1, 1'b0, 2'b00};

        // Reset while a response is outstanding.
        do_reset();
        run_vec(one);
        i_imem_gnt = 1'b1;
        @(negedge i_clk);
        i_imem_gnt = 1'b0;
        chk("fw_req_low", o_imem_req, 32'd0);
        i_reset = 1'b1;
        #1;
        chk("fw_rst_req", o_imem_req, 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        #1;
        chk("fw_rst_vld", o_inst_vld, 32'd0);
        chk("fw_rst_retired", o_retired, 32'd0);
        chk("fw_rst_req_again", o_imem_req, 32'd1);
        chk("fw_rst_addr", o_imem_addr, 32'h0);

        // Reset while holding a stalled instruction.
        run_vec(one);
        serve(0, 1, 32'h0040_0213);
        i_stall = 1'b1;
        @(negedge i_clk);
        chk("hs_vld", o_inst_vld, 32'd1);
        chk("hs_pc", o_pc, 32'h4);
        i_reset = 1'b1;
        #1;
        chk("hs_rst_vld_mask", o_inst_vld, 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        i_stall = 1'b0;
        #1;
        chk("hs_rst_vld", o_inst_vld, 32'd0);
        chk("hs_rst_retired", o_retired, 32'd0);
        chk("hs_rst_addr", o_imem_addr, 32'h0);
        chk("hs_rst_req", o_imem_req, 32'd1);
        chk("hs_rst_inst", o_inst, NOP);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the core. It holds the PC, fetches one 32-bit instruction at a time from instruction memory over a request/grant/response handshake, and presents it to the decode/controller stage. It retires the instruction when the core is not stalled, and computes the next PC from the controller's `pc_sel` and the ALU target. It also halts the core on an illegal instruction or a misaligned redirect, and counts retired instructions.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; must be 4-byte aligned.
- `NOP_INST`, default 32'h0000_0013: value of `o_inst` while no instruction is valid.

Ports:
- `i_clk` in 1: clock; all state updates on the rising edge.
- `i_reset` in 1: reset, synchronous and active-high.
- `o_imem_req` in→out 1: fetch request; `o_imem_req = (state==FETCH_REQ) & ~i_reset`.
- `o_imem_addr` out 32: fetch address, always equal to `o_pc`.
- `i_imem_gnt` in 1: memory accepts the request at an edge where `o_imem_req & i_imem_gnt`.
- `i_imem_rvalid` in 1: response valid, no earlier than the cycle after the grant.
- `i_imem_rdata` in 32: instruction word, qualified by `i_imem_rvalid`.
- `o_inst` out 32: instruction to the controller/decoder.
- `o_pc` out 32: PC of the current instruction.
- `o_inst_vld` out 1: `o_inst`/`o_pc` are valid and executing this cycle.
- `i_stall` in 1: core not ready; hold the current instruction.
- `i_pc_sel` in 1: controller branch/jump taken.
- `i_alu_data` in 32: redirect target (ALU result).
- `i_insn_vld` in 1: controller decoded the current instruction as legal.
- `o_halted` out 1: sticky halt.
- `o_halt_cause` out 2: 00 none, 01 illegal instruction, 10 misaligned target.
- `o_retired` out 32: retired-instruction counter.

## Operation
- FSM states: FETCH_REQ, FETCH_WAIT, HOLD, HALT.
- Reset (`i_reset`=1 at an edge):
  - state←FETCH_REQ, pc←`RESET_PC`, inst←`NOP_INST`.
  - `o_halted`=0, `o_halt_cause`=00, `o_retired`=0.
  - `o_inst_vld`=0 and `o_imem_req`=0 while reset is high.
- FETCH_REQ: `o_imem_req`=1. On an edge with `i_imem_gnt`=1, go to FETCH_WAIT; otherwise stay. `i_imem_rvalid` is ignored in this state.
- FETCH_WAIT: `o_imem_req`=0. On an edge with `i_imem_rvalid`=1, latch `i_imem_rdata` into inst and go to HOLD.
- HOLD: `o_inst_vld`=1. The instruction is consumed at an edge with `i_stall`=0. Checks at consume, in priority order:
  1. `i_insn_vld`=0: state←HALT, cause←01. No retire; pc and inst unchanged.
  2. `i_pc_sel`=1 and `i_alu_data[1:0]`≠00: state←HALT, cause←10. No retire; pc unchanged.
  3. Otherwise: `o_retired`+=1 (wraps modulo 2^32). pc←`i_pc_sel` ? `i_alu_data` : pc+4, with 32-bit wrap (pc 32'hFFFF_FFFC+4 = 0). inst←`NOP_INST`. State←FETCH_REQ.
- With `i_stall`=1 in HOLD: pc, inst and the counter hold. `i_pc_sel`/`i_alu_data` are ignored.
- HALT:
  - `o_halted`=1, `o_inst_vld`=0, `o_imem_req`=0.
  - pc shows the faulting instruction's PC.
  - Only reset leaves HALT.
- `o_halt_cause` holds 00 outside HALT.
- Only one request is outstanding at a time.

## Timing
- `o_imem_req`, `o_inst_vld`, `o_halted` and `o_imem_addr` derive from registered state only. There is no combinational path from `i_imem_*` or `i_stall` to them.
- Zero-wait memory (gnt with req, rvalid the next cycle): 3 cycles per instruction. Cycle n FETCH_REQ, n+1 FETCH_WAIT, n+2 HOLD; next request at n+3.
- First request is visible the cycle after `i_reset` deasserts.
- Each cycle of `i_imem_gnt`=0 adds one cycle in FETCH_REQ. Each cycle without `i_imem_rvalid` adds one cycle in FETCH_WAIT.
- Each stall cycle extends HOLD by one.
- `i_pc_sel`, `i_alu_data` and `i_insn_vld` are sampled only on the consume edge; they may be combinational from `o_inst`.
- Reset during FETCH_WAIT: the instruction memory shares `i_reset` and drops outstanding requests, so no stale `i_imem_rvalid` follows reset.
- Reset in any state has priority over all other events at that edge.

## Test plan
- Reset release, zero-wait memory, mem[0]=32'h00500093:
  - `o_imem_req`=1 with addr 0 the cycle after reset.
  - `o_inst_vld`=1 and `o_inst`=32'h00500093 two cycles later.
  - After consume: `o_retired`=1, next addr=4.
- Straight-line stream, gnt delayed 2 cycles and rvalid delayed 3 cycles per fetch:
  - Addresses 0,4,8.
  - Each HOLD entered 2+3+1 cycles after its request starts.
  - `o_imem_req` never high during FETCH_WAIT.
- Taken branch at pc=8 with `i_pc_sel`=1, `i_alu_data`=32'h40: next addr=32'h40, `o_retired` increments. Same with `i_stall`=1 for 4 cycles: `o_inst`/`o_pc` stable, no request, redirect applied only at the unstalled edge.
- `i_insn_vld`=0 at pc=32'h10: `o_halted`=1, cause=01, `o_pc`=32'h10, `o_retired` unchanged, no further requests. Reset returns `o_pc` to `RESET_PC`.
- Redirect to 32'h22: halt with cause=10 and no retire. Separately, pc=32'hFFFF_FFFC falling through: next addr=0.
- Reset asserted mid-FETCH_WAIT and mid-HOLD with `i_stall`=1: next cycle `o_inst_vld`=0, `o_retired`=0, request restarts at `RESET_PC`.
